if_prefetch_stage: RTL

- Parametrised instruction-fetch stage that decouples instruction memory from decode with a DEPTH-entry prefetch queue.
- Issues sequential fetches through a req/gnt/rvalid memory interface and queues {pc, instruction} pairs.
- Presents queue entries to decode through a valid/ready handshake.
- On branch/jump, flushes the queue and discards any responses still in flight, then redirects fetch.
- Sits between the instruction memory and the decode stage.

---
 rtl/if_prefetch_stage.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: sequential prefetch into a DEPTH-entry queue feeding decode.
// Define IF_MISALIGN_TRAP_EN to trap redirects to misaligned targets (adds misalign_o/misalign_pc_o).
module if_prefetch_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  brj_i,
  input  logic [DATA_WIDTH-1:0] brj_pc_i,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic [DATA_WIDTH-1:0] d_instruction_o,
  output logic [DATA_WIDTH-1:0] d_pc_o,
  output logic [DATA_WIDTH-1:0] d_pc4_o,
  output logic                  flush_o
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] misalign_pc_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]          DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]        FULL_C   = CNT_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0]   PC_INC   = DATA_WIDTH'(4);
  localparam logic [PTR_W-1:0]        PTR_ONE  = PTR_W'(1);

  // Architectural state
  logic [DATA_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_drop;
  logic                  r_flush;
  logic [PTR_W-1:0]      r_q_wptr;
  logic [PTR_W-1:0]      r_q_rptr;
  logic [PTR_W-1:0]      r_s_wptr;
  logic [PTR_W-1:0]      r_s_rptr;

  // Storage (no reset needed; guarded by count/outstanding)
  logic [DATA_WIDTH-1:0] r_q_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] r_q_instr [DEPTH];
  logic [DATA_WIDTH-1:0] r_s_pc    [DEPTH];

  // Next-state and control wires
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic [CNT_W-1:0]      w_count_next;
  logic [CNT_W-1:0]      w_outstanding_next;
  logic [CNT_W-1:0]      w_drop_next;
  logic [PTR_W-1:0]      w_q_wptr_next;
  logic [PTR_W-1:0]      w_q_rptr_next;
  logic [PTR_W-1:0]      w_s_wptr_next;
  logic [PTR_W-1:0]      w_s_rptr_next;
  logic [CNT_W:0]        w_credit_used;
  logic [DATA_WIDTH-1:0] w_brj_pc;
  logic                  w_halt;
  logic                  w_grant;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_resp_drop;
  logic [DATA_WIDTH-1:0] w_head_pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic                  r_misalign;
  logic [DATA_WIDTH-1:0] r_misalign_pc;
  logic                  w_brj_misaligned;

  assign w_brj_pc         = brj_pc_i;
  assign w_brj_misaligned = (brj_pc_i[1:0] != 2'b00);
  assign w_halt           = r_misalign;

  // Sticky until reset or an aligned redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign    <= 1'b0;
      r_misalign_pc <= '0;
    end else if (brj_i) begin
      r_misalign <= w_brj_misaligned;
      if (w_brj_misaligned) begin
        r_misalign_pc <= brj_pc_i;
      end
    end
  end

  assign misalign_o    = r_misalign;
  assign misalign_pc_o = r_misalign_pc;
`else
  assign w_brj_pc = brj_pc_i & ~DATA_WIDTH'(3);
  assign w_halt   = 1'b0;
`endif

  // Credit counts every in-flight request, including ones to be dropped
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
  assign instr_req_o   = !rst && !brj_i && !w_halt && (w_credit_used < DEPTH_C);
  assign instr_addr_o  = r_pc[ADDR_WIDTH-1:0];

  assign w_grant     = instr_req_o && instr_gnt_i;
  assign w_resp_drop = instr_rvalid_i && (r_drop != '0);
  assign w_push      = instr_rvalid_i && (r_drop == '0) && !brj_i;
  assign w_pop       = d_valid_o && d_ready_i && !brj_i;

  always_comb begin
    w_pc_next          = r_pc;
    w_count_next       = r_count;
    w_drop_next        = r_drop;
    w_q_wptr_next      = r_q_wptr;
    w_q_rptr_next      = r_q_rptr;
    w_s_wptr_next      = r_s_wptr;
    w_s_rptr_next      = r_s_rptr;
    w_outstanding_next = r_outstanding + CNT_W'(w_grant) - CNT_W'(instr_rvalid_i);

    // Side FIFO tracks every request regardless of redirects
    if (w_grant) begin
      w_s_wptr_next = r_s_wptr + PTR_ONE;
    end
    if (instr_rvalid_i) begin
      w_s_rptr_next = r_s_rptr + PTR_ONE;
    end

    if (brj_i) begin
      w_pc_next     = w_brj_pc;
      w_count_next  = '0;
      w_q_wptr_next = '0;
      w_q_rptr_next = '0;
      w_drop_next   = w_outstanding_next;
    end else begin
      if (w_grant) begin
        w_pc_next = r_pc + PC_INC;
      end
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        w_q_wptr_next = r_q_wptr + PTR_ONE;
      end
      if (w_pop) begin
        w_q_rptr_next = r_q_rptr + PTR_ONE;
      end
      w_drop_next = r_drop - CNT_W'(w_resp_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_flush       <= 1'b0;
      r_q_wptr      <= '0;
      r_q_rptr      <= '0;
      r_s_wptr      <= '0;
      r_s_rptr      <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_count       <= w_count_next;
      r_outstanding <= w_outstanding_next;
      r_drop        <= w_drop_next;
      r_flush       <= brj_i;
      r_q_wptr      <= w_q_wptr_next;
      r_q_rptr      <= w_q_rptr_next;
      r_s_wptr      <= w_s_wptr_next;
      r_s_rptr      <= w_s_rptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_s_pc[r_s_wptr] <= r_pc;
    end
    if (w_push) begin
      r_q_pc[r_q_wptr]    <= r_s_pc[r_s_rptr];
      r_q_instr[r_q_wptr] <= instr_rdata_i;
    end
  end

  assign w_head_pc       = r_q_pc[r_q_rptr];
  assign d_valid_o       = (r_count != '0);
  assign flush_o         = r_flush;
  assign d_instruction_o = d_valid_o ? r_q_instr[r_q_rptr] : NOP_INSTR;
  assign d_pc_o          = d_valid_o ? w_head_pc : '0;
  assign d_pc4_o         = d_valid_o ? (w_head_pc + PC_INC) : '0;

  // Credit rule makes a push into a full queue impossible
  assert property (@(posedge clk) disable iff (rst) !(w_push && !w_pop && (r_count == FULL_C)));
  assert property (@(posedge clk) disable iff (rst) !(instr_rvalid_i && (r_outstanding == '0)));
  assert property (@(posedge clk) disable iff (rst) r_drop <= r_outstanding);

endmodule
